// File: rtl/debounced_counter.sv
// Multi-channel switch debouncer with hysteresis and per-channel release counters.
// Optional feature macro: DC_UPDOWN_EN adds the per-channel dir input for down counting.
module debounced_counter #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned SHIFT_LEN = 5,
    parameter int unsigned SAT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw_in,
`ifdef DC_UPDOWN_EN
    input  logic [N_CH-1:0]         dir,
`endif
    output logic [N_CH-1:0]         sw_db,
    output logic [N_CH-1:0]         sw_fall,
    output logic [N_CH*CNT_W-1:0]   q
);

    logic [DIV_W-1:0] r_presc;
    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic             w_tick;

    assign w_tick = &r_presc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SHIFT_LEN-1:0] r_sh;
        logic                 r_db;
        logic                 r_db_q;
        logic                 r_fall;
        logic [CNT_W-1:0]     r_cnt;
        logic [CNT_W-1:0]     w_cnt_nxt;

        // Hysteresis: a set level needs an all-zero history to clear, a clear one all-ones to set.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sh   <= '0;
                r_db   <= 1'b0;
                r_db_q <= 1'b0;
                r_fall <= 1'b0;
                r_cnt  <= '0;
            end else begin
                if (w_tick) begin
                    r_sh <= {r_sh[SHIFT_LEN-2:0], r_sync2[g]};
                    r_db <= r_db ? |r_sh : &r_sh;
                end
                r_db_q <= r_db;
                r_fall <= r_db_q & ~r_db;
                r_cnt  <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (r_fall) begin
`ifdef DC_UPDOWN_EN
                if (dir[g]) begin
                    if (SAT == 0 || r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
                end else
`endif
                if (SAT == 0 || r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        assign sw_db[g]                = r_db;
        assign sw_fall[g]              = r_fall;
        assign q[g*CNT_W +: CNT_W]     = r_cnt;
    end

endmodule

// File: tb/tb_debounced_counter.sv
// Directed bench for debounced_counter: one wrapping and one saturating instance on shared inputs.
module tb_debounced_counter;

    logic       clk;
    logic       rst;
    logic [1:0] sw_in;
    logic [1:0] dir_r;
    logic [1:0] db_a, db_b, fall_a, fall_b;
    logic [7:0] q_a, q_b;

    int n_checks;
    int n_fail;
    int n_fall0, n_both, n_single, db_seen;

    debounced_counter #(
        .N_CH(2), .CNT_W(4), .DIV_W(2), .SHIFT_LEN(5), .SAT(0)
    ) u_wrap (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
`ifdef DC_UPDOWN_EN
        .dir(dir_r),
`endif
        .sw_db(db_a),
        .sw_fall(fall_a),
        .q(q_a)
    );

    debounced_counter #(
        .N_CH(2), .CNT_W(4), .DIV_W(2), .SHIFT_LEN(5), .SAT(1)
    ) u_sat (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
`ifdef DC_UPDOWN_EN
        .dir(dir_r),
`endif
        .sw_db(db_b),
        .sw_fall(fall_b),
        .q(q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_fall0  = 0;
        n_both   = 0;
        n_single = 0;
        db_seen  = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (fall_a[0]) n_fall0++;
            if (fall_a == 2'b11) n_both++;
            if (fall_a == 2'b01 || fall_a == 2'b10) n_single++;
            if (db_a[0]) db_seen = 1;
        end
    endtask

    task automatic press_release(input logic [1:0] mask);
        sw_in = mask;
        run_cycles(32);
        sw_in = 2'b00;
        run_cycles(32);
    endtask

    initial begin
        int rise_t, fall_t, pulses;
        n_checks = 0;
        n_fail   = 0;
        clear_counts();
        rst   = 1'b1;
        sw_in = 2'b00;
        dir_r = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_q_wrap", q_a, 8'h00);
        check("reset_q_sat", q_b, 8'h00);
        check("reset_db", db_a, 2'b00);
        check("reset_fall", fall_a, 2'b00);
        rst = 1'b0;

        // Clean press/release on ch0
        sw_in  = 2'b01;
        rise_t = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rise_t == 0 && db_a[0]) rise_t = k;
        end
        check("rise_latency_ok", (rise_t >= 22 && rise_t <= 26), 1);
        check("db_high_after_press", db_a[0], 1'b1);
        sw_in  = 2'b00;
        fall_t = 0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fall_t == 0 && !db_a[0]) fall_t = k;
            if (fall_a[0]) pulses++;
        end
        check("fall_latency_ok", (fall_t >= 22 && fall_t <= 26), 1);
        check("one_fall_pulse", pulses, 1);
        check("clean_q_wrap", q_a, 8'h01);
        check("clean_q_sat", q_b, 8'h01);

        // Chatter rejection: period-6 toggling never yields 5 consecutive equal samples
        clear_counts();
        for (int k = 0; k < 20; k++) begin
            sw_in[0] = ~sw_in[0];
            run_cycles(3);
        end
        sw_in = 2'b00;
        run_cycles(40);
        check("chatter_db_stays_low", db_seen, 0);
        check("chatter_no_fall", n_fall0, 0);
        check("chatter_q_unchanged", q_a, 8'h01);

        // Simultaneous releases on both channels
        clear_counts();
        press_release(2'b11);
        check("simul_both_pulse", n_both, 1);
        check("simul_no_single", n_single, 0);
        check("simul_q_wrap", q_a, 8'h12);
        check("simul_q_sat", q_b, 8'h12);

        // Build q = 0x35 then reset asynchronously with both switches debounced high
        repeat (3) press_release(2'b01);
        repeat (2) press_release(2'b10);
        check("pre_reset_q_wrap", q_a, 8'h35);
        check("pre_reset_q_sat", q_b, 8'h35);
        sw_in = 2'b11;
        run_cycles(30);
        check("pre_reset_db", db_a, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("async_reset_q_wrap", q_a, 8'h00);
        check("async_reset_q_sat", q_b, 8'h00);
        check("async_reset_db", db_a, 2'b00);
        sw_in = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("no_fall_after_reset", fall_a | fall_b, 2'b00);
        press_release(2'b01);
        check("post_reset_q_wrap", q_a, 8'h01);
        check("post_reset_q_sat", q_b, 8'h01);

        // Wrap vs saturate: 17 releases on ch1 from 0, then one more
        repeat (17) press_release(2'b10);
        check("ch1_17_wrap", q_a[7:4], 4'd1);
        check("ch1_17_sat", q_b[7:4], 4'd15);
        press_release(2'b10);
        check("ch1_18_wrap", q_a[7:4], 4'd2);
        check("ch1_18_sat_holds", q_b[7:4], 4'd15);
        check("ch0_untouched", q_a[3:0], 4'd1);

`ifdef DC_UPDOWN_EN
        // Down count from 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        dir_r = 2'b01;
        press_release(2'b01);
        check("down_wrap", q_a[3:0], 4'd15);
        check("down_sat", q_b[3:0], 4'd0);
        dir_r = 2'b00;
        press_release(2'b01);
        check("up_after_down_wrap", q_a[3:0], 4'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
